// File: rtl/cpu_control_pkg.sv
// cpu_control_pkg: control-field enums, the packed control vector and opcode constants
// shared by the SM83 micro-sequencer and its datapath.
package cpu_control_pkg;

    typedef enum logic {PC_NEXT_SAME = 1'b0, PC_NEXT_INC = 1'b1} pc_next_e;

    typedef enum logic [2:0] {
        REG_A        = 3'd0,
        REG_W        = 3'd1,
        REG_Z        = 3'd2,
        REG_8SRC     = 3'd3,
        REG_8DEST    = 3'd4,
        REG_HL       = 3'd5
    } reg_sel_e;

    typedef enum logic [2:0] {
        REG_OP_NONE      = 3'd0,
        REG_OP_WRITE_ALU = 3'd1,
        REG_OP_WRITE_MEM = 3'd2,
        REG_OP_INC_HL    = 3'd3,
        REG_OP_DEC_HL    = 3'd4
    } reg_op_e;

    typedef enum logic {ALU_OP_COPY_A = 1'b0, ALU_OP_INC_A = 1'b1} alu_op_e;
    typedef enum logic {ALU_SEL_A_REG1 = 1'b0} alu_sel_a_e;
    typedef enum logic {ALU_SEL_B_REG2 = 1'b0} alu_sel_b_e;

    typedef enum logic [1:0] {
        ADDR_PC  = 2'd0,
        ADDR_HL  = 2'd1,
        ADDR_REG = 2'd2
    } mem_addr_sel_e;

    typedef struct packed {
        pc_next_e      pc_next;
        logic          inst_load;
        reg_sel_e      reg_read1_sel;
        reg_sel_e      reg_read2_sel;
        reg_sel_e      reg_write_sel;
        reg_op_e       reg_op;
        alu_op_e       alu_op;
        alu_sel_a_e    alu_sel_a;
        alu_sel_b_e    alu_sel_b;
        logic          mem_enable;
        logic          mem_write;
        mem_addr_sel_e mem_addr_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        pc_next: PC_NEXT_SAME, inst_load: 1'b0,
        reg_read1_sel: REG_A, reg_read2_sel: REG_A, reg_write_sel: REG_A,
        reg_op: REG_OP_NONE, alu_op: ALU_OP_COPY_A,
        alu_sel_a: ALU_SEL_A_REG1, alu_sel_b: ALU_SEL_B_REG2,
        mem_enable: 1'b0, mem_write: 1'b0, mem_addr_sel: ADDR_PC
    };

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_HALT     = 8'h76;
    localparam logic [7:0] OP_LD_HL_N  = 8'h36;
    localparam logic [7:0] OP_LDI_HL_A = 8'h22;
    localparam logic [7:0] OP_LDD_HL_A = 8'h32;
    localparam logic [7:0] OP_LDI_A_HL = 8'h2A;
    localparam logic [7:0] OP_LDD_A_HL = 8'h3A;
    localparam logic [7:0] OP_LD_A_NN  = 8'hFA;

endpackage

// File: rtl/cpu_control_decode.sv
// cpu_control_decode: (opcode, step) -> per-M-cycle control vector.
// Optional INC r support is enabled by defining CPU_CONTROL_INC_EN.
module cpu_control_decode
    import cpu_control_pkg::*;
(
    input  logic [7:0] opcode_i,
    input  logic [1:0] step_i,
    output ctrl_t      ctrl_o
);

    logic fetch;
    logic s0;

    assign s0 = (step_i == 2'd0);

    // Each branch clears fetch only for its non-final cycles; any other step is FETCH.
    always_comb begin
        ctrl_o = CTRL_IDLE;
        fetch  = 1'b1;
        if (opcode_i == OP_LD_HL_N) begin
            fetch = step_i[1];
            if (s0) begin
                ctrl_o.mem_enable = 1'b1; ctrl_o.pc_next = PC_NEXT_INC;
                ctrl_o.reg_op = REG_OP_WRITE_MEM; ctrl_o.reg_write_sel = REG_Z;
            end else if (step_i == 2'd1) begin
                ctrl_o.mem_addr_sel = ADDR_HL; ctrl_o.mem_enable = 1'b1;
                ctrl_o.mem_write = 1'b1; ctrl_o.reg_read1_sel = REG_Z;
            end
        end else if (opcode_i == OP_LD_A_NN) begin
            fetch = (step_i == 2'd3);
            if (!step_i[1]) begin
                ctrl_o.mem_enable = 1'b1; ctrl_o.pc_next = PC_NEXT_INC;
                ctrl_o.reg_op = REG_OP_WRITE_MEM;
                ctrl_o.reg_write_sel = s0 ? REG_Z : REG_W;
            end else if (step_i == 2'd2) begin
                ctrl_o.mem_addr_sel = ADDR_REG; ctrl_o.mem_enable = 1'b1;
                ctrl_o.reg_read1_sel = REG_W; ctrl_o.reg_read2_sel = REG_Z;
                ctrl_o.reg_op = REG_OP_WRITE_MEM; ctrl_o.reg_write_sel = REG_A;
            end
        end else if (opcode_i == OP_LDI_HL_A || opcode_i == OP_LDD_HL_A) begin
            fetch = !s0;
            if (s0) begin
                ctrl_o.mem_addr_sel = ADDR_HL; ctrl_o.mem_enable = 1'b1;
                ctrl_o.mem_write = 1'b1; ctrl_o.reg_read1_sel = REG_A;
                ctrl_o.reg_op = opcode_i[4] ? REG_OP_DEC_HL : REG_OP_INC_HL;
            end
        end else if (opcode_i == OP_LDI_A_HL || opcode_i == OP_LDD_A_HL) begin
            fetch = !s0;
            if (s0) begin
                ctrl_o.mem_addr_sel = ADDR_HL; ctrl_o.mem_enable = 1'b1;
                ctrl_o.reg_op = REG_OP_WRITE_MEM; ctrl_o.reg_write_sel = REG_A;
            end else if (step_i == 2'd1) begin
                ctrl_o.reg_op = opcode_i[4] ? REG_OP_DEC_HL : REG_OP_INC_HL;
            end
        end else if (opcode_i[7:6] == 2'b01 && opcode_i != OP_HALT) begin
            if (opcode_i[2:0] == 3'b110) begin
                fetch = !s0;
                if (s0) begin
                    ctrl_o.mem_addr_sel = ADDR_HL; ctrl_o.mem_enable = 1'b1;
                    ctrl_o.reg_op = REG_OP_WRITE_MEM; ctrl_o.reg_write_sel = REG_8DEST;
                end
            end else if (opcode_i[5:3] == 3'b110) begin
                fetch = !s0;
                if (s0) begin
                    ctrl_o.mem_addr_sel = ADDR_HL; ctrl_o.mem_enable = 1'b1;
                    ctrl_o.mem_write = 1'b1; ctrl_o.reg_read1_sel = REG_8SRC;
                end
            end else if (s0) begin
                ctrl_o.reg_read1_sel = REG_8SRC; ctrl_o.reg_op = REG_OP_WRITE_ALU;
                ctrl_o.reg_write_sel = REG_8DEST;
            end
        end else if (opcode_i[7:6] == 2'b00 && opcode_i[2:0] == 3'b110) begin
            fetch = !s0;
            if (s0) begin
                ctrl_o.mem_enable = 1'b1; ctrl_o.pc_next = PC_NEXT_INC;
                ctrl_o.reg_op = REG_OP_WRITE_MEM; ctrl_o.reg_write_sel = REG_8DEST;
            end
        end
`ifdef CPU_CONTROL_INC_EN
        else if (opcode_i[7:6] == 2'b00 && opcode_i[2:0] == 3'b100 && opcode_i[5:3] != 3'b110) begin
            if (s0) begin
                ctrl_o.reg_read1_sel = REG_8DEST; ctrl_o.alu_op = ALU_OP_INC_A;
                ctrl_o.reg_op = REG_OP_WRITE_ALU; ctrl_o.reg_write_sel = REG_8DEST;
            end
        end
`endif
        if (fetch) begin
            ctrl_o.mem_addr_sel = ADDR_PC; ctrl_o.mem_enable = 1'b1;
            ctrl_o.mem_write = 1'b0; ctrl_o.pc_next = PC_NEXT_INC;
            ctrl_o.inst_load = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_control.sv
// cpu_control: SM83 micro-sequencer; holds opcode/step and exposes the decoded controls.
// Define CPU_CONTROL_INC_EN to decode INC r (handled in cpu_control_decode).
module cpu_control
    import cpu_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] t_cycle,
    input  logic [7:0] mem_data_in,
    output logic       pc_next,
    output logic       inst_load,
    output logic [2:0] reg_read1_sel,
    output logic [2:0] reg_read2_sel,
    output logic [2:0] reg_write_sel,
    output logic [2:0] reg_op,
    output logic       alu_op,
    output logic       alu_sel_a,
    output logic       alu_sel_b,
    output logic       mem_enable,
    output logic       mem_write,
    output logic [1:0] mem_addr_sel
);

    logic [7:0] opcode_q, opcode_d;
    logic [1:0] step_q, step_d;
    ctrl_t      ctrl;

    cpu_control_decode u_decode (
        .opcode_i (opcode_q),
        .step_i   (step_q),
        .ctrl_o   (ctrl)
    );

    // State advances only on the last T-cycle, alongside the datapath's sampling point.
    always_comb begin
        opcode_d = opcode_q;
        step_d   = step_q;
        if (t_cycle == 2'd3) begin
            opcode_d = ctrl.inst_load ? mem_data_in : opcode_q;
            step_d   = ctrl.inst_load ? 2'd0 : step_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q <= OP_NOP;
            step_q   <= 2'd0;
        end else begin
            opcode_q <= opcode_d;
            step_q   <= step_d;
        end
    end

    assign pc_next       = ctrl.pc_next;
    assign inst_load     = ctrl.inst_load;
    assign reg_read1_sel = ctrl.reg_read1_sel;
    assign reg_read2_sel = ctrl.reg_read2_sel;
    assign reg_write_sel = ctrl.reg_write_sel;
    assign reg_op        = ctrl.reg_op;
    assign alu_op        = ctrl.alu_op;
    assign alu_sel_a     = ctrl.alu_sel_a;
    assign alu_sel_b     = ctrl.alu_sel_b;
    assign mem_enable    = ctrl.mem_enable;
    assign mem_write     = ctrl.mem_write;
    assign mem_addr_sel  = ctrl.mem_addr_sel;

endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: directed M-cycle vectors for cpu_control with hand-computed control words.
module tb_cpu_control;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] t_cycle;
    logic [7:0] mem_data_in;
    logic       pc_next, inst_load, alu_op, alu_sel_a, alu_sel_b, mem_enable, mem_write;
    logic [2:0] reg_read1_sel, reg_read2_sel, reg_write_sel, reg_op;
    logic [1:0] mem_addr_sel;
    int         n_vec = 0;
    int         n_err = 0;

    cpu_control dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .t_cycle       (t_cycle),
        .mem_data_in   (mem_data_in),
        .pc_next       (pc_next),
        .inst_load     (inst_load),
        .reg_read1_sel (reg_read1_sel),
        .reg_read2_sel (reg_read2_sel),
        .reg_write_sel (reg_write_sel),
        .reg_op        (reg_op),
        .alu_op        (alu_op),
        .alu_sel_a     (alu_sel_a),
        .alu_sel_b     (alu_sel_b),
        .mem_enable    (mem_enable),
        .mem_write     (mem_write),
        .mem_addr_sel  (mem_addr_sel)
    );

    always #5 clk = ~clk;

    // Control word layout: pc,il,r1,r2,w,op,alu,sa,sb,en,wr,addr (sa/sb always 0).
    function automatic logic [20:0] cw(input logic pc, input logic il, input logic [2:0] r1,
                                       input logic [2:0] r2, input logic [2:0] w, input logic [2:0] op,
                                       input logic alu, input logic en, input logic wr, input logic [1:0] ad);
        return {pc, il, r1, r2, w, op, alu, 1'b0, 1'b0, en, wr, ad};
    endfunction

    logic [20:0] obs;
    assign obs = {pc_next, inst_load, reg_read1_sel, reg_read2_sel, reg_write_sel, reg_op,
                  alu_op, alu_sel_a, alu_sel_b, mem_enable, mem_write, mem_addr_sel};

    task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    // One M-cycle: check outputs at T0, hold them stable through T3, bus = opcode source.
    task automatic mcyc(input string tag, input logic [7:0] bus, input logic [20:0] exp);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            t_cycle     = 2'(t);
            mem_data_in = bus;
            if (t == 0) check(tag, obs, exp);
            if (t == 3) check({tag, "_t3"}, obs, exp);
        end
    endtask

    localparam logic [20:0] FETCH = 21'h0;
    logic [20:0] fetch_w, inc_w;

    initial begin
        fetch_w = cw(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
`ifdef CPU_CONTROL_INC_EN
        inc_w = cw(1, 1, 4, 0, 4, 1, 1, 1, 0, 0);
`else
        inc_w = fetch_w;
`endif
        reset_n = 1'b0; t_cycle = 2'd0; mem_data_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset", obs, fetch_w);
        reset_n = 1'b1;
        mcyc("nop_fetch", 8'h00, fetch_w);
        mcyc("nop_again", 8'h78, fetch_w);
        mcyc("ld_a_b", 8'h36, cw(1, 1, 3, 0, 4, 1, 0, 1, 0, 0));
        mcyc("ldhln_m1", 8'h00, cw(1, 0, 0, 0, 2, 2, 0, 1, 0, 0));
        mcyc("ldhln_m2", 8'h00, cw(0, 0, 2, 0, 0, 0, 0, 1, 1, 1));
        mcyc("ldhln_m3", 8'h2A, fetch_w);
        mcyc("ldi_a_m1", 8'h00, cw(0, 0, 0, 0, 0, 2, 0, 1, 0, 1));
        mcyc("ldi_a_m2", 8'h3A, cw(1, 1, 0, 0, 0, 3, 0, 1, 0, 0));
        mcyc("ldd_a_m1", 8'h00, cw(0, 0, 0, 0, 0, 2, 0, 1, 0, 1));
        mcyc("ldd_a_m2", 8'hFA, cw(1, 1, 0, 0, 0, 4, 0, 1, 0, 0));
        mcyc("ldann_m1", 8'h00, cw(1, 0, 0, 0, 2, 2, 0, 1, 0, 0));
        mcyc("ldann_m2", 8'h00, cw(1, 0, 0, 0, 1, 2, 0, 1, 0, 0));
        mcyc("ldann_m3", 8'h00, cw(0, 0, 1, 2, 0, 2, 0, 1, 0, 2));
        mcyc("ldann_m4", 8'hFA, fetch_w);
        mcyc("abort_m1", 8'h00, cw(1, 0, 0, 0, 2, 2, 0, 1, 0, 0));
        @(negedge clk);
        t_cycle = 2'd0;
        check("abort_m2", obs, cw(1, 0, 0, 0, 1, 2, 0, 1, 0, 0));
        @(negedge clk);
        t_cycle = 2'd1;
        reset_n = 1'b0;
        #1 check("abort_rst", obs, fetch_w);
        @(negedge clk);
        reset_n = 1'b1;
        mcyc("post_rst", 8'h3C, fetch_w);
        mcyc("inc_a", 8'h22, inc_w);
        mcyc("ldi_hl_m1", 8'h76, cw(0, 0, 0, 0, 0, 3, 0, 1, 1, 1));
        mcyc("ldi_hl_m2", 8'h76, fetch_w);
        mcyc("halt", 8'h46, fetch_w);
        mcyc("ld_b_hl_m1", 8'h00, cw(0, 0, 0, 0, 4, 2, 0, 1, 0, 1));
        mcyc("ld_b_hl_m2", 8'h70, fetch_w);
        mcyc("ld_hl_b_m1", 8'h00, cw(0, 0, 3, 0, 0, 0, 0, 1, 1, 1));
        mcyc("ld_hl_b_m2", 8'h06, fetch_w);
        mcyc("ld_b_n_m1", 8'h00, cw(1, 0, 0, 0, 4, 2, 0, 1, 0, 0));
        mcyc("ld_b_n_m2", 8'h00, fetch_w);
        check("idle_not_fetch", obs == FETCH ? 21'h1 : 21'h0, 21'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
